// File: rtl/wbm_initiator.sv
// Wishbone B4 classic-cycle bus master: runs single or incrementing-burst
// commands from a local command port and returns one response per beat.
module wbm_initiator #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  wbm_clk_i,
  input  logic                  wbm_rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_W-1:0]     cmd_adr_i,
  input  logic [DATA_W-1:0]     cmd_dat_i,
  input  logic [DATA_W/8-1:0]   cmd_sel_i,
  input  logic [LEN_W-1:0]      cmd_len_i,
  output logic                  rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_tmo_o,
  output logic                  rsp_last_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [ADDR_W-1:0]     wbm_adr_o,
  output logic [DATA_W-1:0]     wbm_dat_o,
  output logic [DATA_W/8-1:0]   wbm_sel_o,
  input  logic [DATA_W-1:0]     wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_cyc, r_stb, r_we, r_rdy;
  logic [ADDR_W-1:0]   r_adr;
  logic [DATA_W-1:0]   r_dat;
  logic [SEL_W-1:0]    r_sel;
  logic [LEN_W-1:0]    r_len, r_beat;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_rsp_valid, r_rsp_err, r_rsp_tmo, r_rsp_last;
  logic [DATA_W-1:0]   r_rsp_dat;

  logic                w_cyc, w_stb, w_we, w_rdy;
  logic [ADDR_W-1:0]   w_adr;
  logic [DATA_W-1:0]   w_dat;
  logic [SEL_W-1:0]    w_sel;
  logic [LEN_W-1:0]    w_len, w_beat;
  logic [TMO_W-1:0]    w_tmo;
  logic                w_rsp_valid, w_rsp_err, w_rsp_tmo, w_rsp_last;
  logic [DATA_W-1:0]   w_rsp_dat;

  logic                w_ack, w_err, w_tmo_hit, w_last;

  // ERR has priority over a simultaneous ACK
  assign w_err     = wbm_err_i;
  assign w_ack     = wbm_ack_i & ~wbm_err_i;
  assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_last    = (r_beat == r_len);

  always_ff @(posedge wbm_clk_i) begin
    if (wbm_rst_i) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_rdy       <= 1'b1;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_tmo       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_dat   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cyc       <= w_cyc;
      r_stb       <= w_stb;
      r_we        <= w_we;
      r_rdy       <= w_rdy;
      r_adr       <= w_adr;
      r_dat       <= w_dat;
      r_sel       <= w_sel;
      r_len       <= w_len;
      r_beat      <= w_beat;
      r_tmo       <= w_tmo;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_tmo   <= w_rsp_tmo;
      r_rsp_last  <= w_rsp_last;
      r_rsp_dat   <= w_rsp_dat;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (cmd_valid_i) w_state_nxt = S_STROBE;
      S_STROBE: begin
        if (w_err || w_tmo_hit) w_state_nxt = S_IDLE;
        else if (w_ack)         w_state_nxt = w_last ? S_IDLE : S_GAP;
      end
      S_GAP:    w_state_nxt = S_STROBE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; ready mirrors the next state
  always_comb begin
    w_cyc       = r_cyc;
    w_stb       = r_stb;
    w_we        = r_we;
    w_adr       = r_adr;
    w_dat       = r_dat;
    w_sel       = r_sel;
    w_len       = r_len;
    w_beat      = r_beat;
    w_tmo       = r_tmo;
    w_rdy       = (w_state_nxt == S_IDLE);
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_tmo   = 1'b0;
    w_rsp_last  = 1'b0;
    w_rsp_dat   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_cyc  = 1'b1;
          w_stb  = 1'b1;
          w_we   = cmd_we_i;
          w_adr  = cmd_adr_i;
          w_dat  = cmd_dat_i;
          w_sel  = cmd_sel_i;
          w_len  = cmd_len_i;
          w_beat = '0;
          w_tmo  = '0;
        end
      end
      S_STROBE: begin
        if (w_err) begin
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_last  = 1'b1;
          w_cyc       = 1'b0;
          w_stb       = 1'b0;
        end else if (w_ack) begin
          w_rsp_valid = 1'b1;
          w_rsp_last  = w_last;
          w_rsp_dat   = r_we ? '0 : wbm_dat_i;
          w_stb       = 1'b0;
          if (w_last) begin
            w_cyc = 1'b0;
          end else begin
            w_adr  = r_adr + ADDR_W'(SEL_W);
            w_beat = r_beat + 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_tmo   = 1'b1;
          w_rsp_last  = 1'b1;
          w_cyc       = 1'b0;
          w_stb       = 1'b0;
        end else begin
          w_tmo = r_tmo + 1'b1;
        end
      end
      S_GAP: begin
        w_stb = 1'b1;
        w_tmo = '0;
      end
      default: begin
        w_cyc = 1'b0;
        w_stb = 1'b0;
      end
    endcase
  end

  assign cmd_ready_o = r_rdy;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_tmo_o   = r_rsp_tmo;
  assign rsp_last_o  = r_rsp_last;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_stb;
  assign wbm_we_o    = r_we;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign wbm_sel_o   = r_sel;

endmodule

// File: tb/tb_wbm_initiator.sv
// Scoreboard bench for wbm_initiator: a behavioural Wishbone slave plus
// expected-beat and expected-response queues checked by a negedge monitor.
module tb_wbm_initiator;

  localparam int unsigned AW = 32, DW = 32, LW = 4, TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic [3:0]    cmd_sel;
  logic [LW-1:0] cmd_len;
  logic          rsp_valid, rsp_err, rsp_tmo, rsp_last;
  logic [DW-1:0] rsp_dat;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o, dat_i;
  logic [3:0]    sel;
  logic          ack, err;

  always #5 clk = ~clk;

  wbm_initiator #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(TMO)) dut (
    .wbm_clk_i(clk), .wbm_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel), .cmd_len_i(cmd_len),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .rsp_tmo_o(rsp_tmo), .rsp_last_o(rsp_last),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(dat_o), .wbm_sel_o(sel),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err)
  );

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
  } beat_t;

  typedef struct {
    logic [DW-1:0] dat;
    logic          chk_dat;
    logic          err;
    logic          tmo;
    logic          last;
  } rsp_t;

  beat_t exp_beat[$];
  rsp_t  exp_rsp[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Slave: responds after slv_wait idle STB cycles; ERR on beat slv_err_beat
  int            slv_wait     = 0;
  int            slv_err_beat = -1;
  logic          slv_silent   = 1'b0;
  logic [DW-1:0] slv_data[16];
  int            slv_wcnt     = 0;
  int            slv_beat     = 0;

  always @(negedge clk) begin
    ack   = 1'b0;
    err   = 1'b0;
    dat_i = '0;
    if (!cyc) slv_beat = 0;
    if (stb && !slv_silent) begin
      if (slv_wcnt == slv_wait) begin
        if (slv_beat == slv_err_beat) err = 1'b1;
        else begin
          ack   = 1'b1;
          dat_i = slv_data[slv_beat % 16];
        end
        slv_beat++;
        slv_wcnt = 0;
      end else begin
        slv_wcnt++;
      end
    end else if (!stb) begin
      slv_wcnt = 0;
    end
  end

  logic prev_stb     = 1'b0;
  int   stb_len      = 0;
  int   last_stb_len = 0;
  int   gap_run      = 0;

  always @(negedge clk) begin
    beat_t b;
    rsp_t  r;
    if (!rst) begin
      if (stb && !prev_stb) begin
        check_eq("cyc_with_stb", cyc, 1);
        if (gap_run > 0) check_eq("gap_len", gap_run, 1);
        gap_run = 0;
        if (exp_beat.size() == 0) check_eq("beat_extra", exp_beat.size(), 1);
        else begin
          b = exp_beat.pop_front();
          check_eq("adr", adr, b.adr);
          check_eq("we", we, b.we);
          check_eq("sel", sel, b.sel);
          if (b.we) check_eq("wdat", dat_o, b.dat);
        end
      end
      if (cyc && !stb) gap_run++;
      if (!cyc) gap_run = 0;
      if (stb) stb_len++;
      else if (prev_stb) begin
        last_stb_len = stb_len;
        stb_len = 0;
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) check_eq("rsp_extra", exp_rsp.size(), 1);
        else begin
          r = exp_rsp.pop_front();
          if (r.chk_dat) check_eq("rsp_dat", rsp_dat, r.dat);
          check_eq("rsp_err", rsp_err, r.err);
          check_eq("rsp_tmo", rsp_tmo, r.tmo);
          check_eq("rsp_last", rsp_last, r.last);
          check_eq("ready_vs_last", cmd_ready, r.last);
          if (r.last) check_eq("cyc_after_last", cyc, 0);
        end
      end
      prev_stb = stb;
    end
  end

  task automatic push_beat(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input logic [3:0] s);
    beat_t b;
    b.adr = a; b.we = w; b.dat = d; b.sel = s;
    exp_beat.push_back(b);
  endtask

  task automatic push_rsp(input logic [DW-1:0] d, input logic cd, input logic e, input logic t, input logic l);
    rsp_t r;
    r.dat = d; r.chk_dat = cd; r.err = e; r.tmo = t; r.last = l;
    exp_rsp.push_back(r);
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] s, input logic [LW-1:0] l);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check_eq("issue_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("accept_to_stb", stb, 1);
    check_eq("ready_busy", cmd_ready, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_rsp.size() != 0 || !cmd_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq("done_rsp_left", exp_rsp.size(), 0);
    check_eq("done_beat_left", exp_beat.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; cmd_len = '0;
    ack = 1'b0; err = 1'b0; dat_i = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_cyc", cyc, 0);
    check_eq("rst_stb", stb, 0);
    check_eq("rst_we", we, 0);
    check_eq("rst_adr", adr, 0);
    check_eq("rst_dat", dat_o, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_tmo, rsp_last}, 0);
    check_eq("rst_rsp_dat", rsp_dat, 0);
    check_eq("rst_ready", cmd_ready, 1);
    rst = 1'b0;

    // single write, ACK 2 cycles after STB
    slv_wait = 2;
    push_beat(32'h100, 1'b1, 32'hDEADBEEF, 4'hF);
    push_rsp(32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 4'd0);
    wait_done();
    check_eq("wr_stb_len", last_stb_len, 3);

    // 4-beat read burst, zero-wait
    slv_wait = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      slv_data[i] = 32'h11 * (i + 1);
      push_beat(32'h1000 + 4 * i, 1'b0, 32'h0, 4'hF);
      push_rsp(32'h11 * (i + 1), 1'b1, 1'b0, 1'b0, i == 3);
    end
    issue(1'b0, 32'h1000, 32'h0, 4'hF, 4'd3);
    wait_done();

    // len=7 read, ERR on 3rd beat
    slv_err_beat = 2;
    for (int unsigned i = 0; i < 3; i++) begin
      slv_data[i] = 32'hA0 + i;
      push_beat(32'h2000 + 4 * i, 1'b0, 32'h0, 4'h3);
      push_rsp(32'hA0 + i, i != 2, i == 2, 1'b0, i == 2);
    end
    issue(1'b0, 32'h2000, 32'h0, 4'h3, 4'd7);
    wait_done();
    slv_err_beat = -1;

    // silent slave -> timeout
    slv_silent = 1'b1;
    push_beat(32'h300, 1'b1, 32'h12345678, 4'h1);
    push_rsp(32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    issue(1'b1, 32'h300, 32'h12345678, 4'h1, 4'd0);
    wait_done();
    check_eq("tmo_stb_len", last_stb_len, TMO);
    slv_silent = 1'b0;

    // reset during STROBE of a 4-beat read
    slv_wait = 5;
    push_beat(32'h4000, 1'b0, 32'h0, 4'hF);
    issue(1'b0, 32'h4000, 32'h0, 4'hF, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mrst_cyc", cyc, 0);
    check_eq("mrst_stb", stb, 0);
    check_eq("mrst_rsp", rsp_valid, 0);
    check_eq("mrst_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    check_eq("mrst_beats", exp_beat.size(), 0);
    slv_wait = 0;
    slv_data[0] = 32'hCAFEF00D;
    push_beat(32'h40, 1'b0, 32'h0, 4'hF);
    push_rsp(32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 32'h40, 32'h0, 4'hF, 4'd0);
    wait_done();

    // address wrap at the top of the space
    slv_wait = 1;
    for (int unsigned i = 0; i < 3; i++) begin
      slv_data[i] = 32'h5000 + i;
      push_rsp(32'h5000 + i, 1'b1, 1'b0, 1'b0, i == 2);
    end
    push_beat(32'hFFFFFFF8, 1'b0, 32'h0, 4'hF);
    push_beat(32'hFFFFFFFC, 1'b0, 32'h0, 4'hF);
    push_beat(32'h00000000, 1'b0, 32'h0, 4'hF);
    issue(1'b0, 32'hFFFFFFF8, 32'h0, 4'hF, 4'd2);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
